// File: rtl/vscpu_ram_loader_if.sv
// Bus bundle between the VerySimpleCPU / boot host and vscpu_ram_loader.
//   CPU side : wrEn, addr_toRAM, data_toRAM -> ; <- data_fromRAM, cpu_rst
//   Host side: ld_valid, ld_byte, ld_last, ld_start -> ; <- ld_ready, ld_overflow
// slave  = the memory/loader block, master = whoever drives CPU + host signals.
interface vscpu_ram_loader_if #(
  parameter int SIZE = 14
);
  logic            wrEn;
  logic [SIZE-1:0] addr_toRAM;
  logic [31:0]     data_toRAM;
  logic [31:0]     data_fromRAM;
  logic            ld_valid;
  logic [7:0]      ld_byte;
  logic            ld_last;
  logic            ld_ready;
  logic            ld_start;
  logic            ld_overflow;
  logic            cpu_rst;

  modport slave (
    input  wrEn, addr_toRAM, data_toRAM, ld_valid, ld_byte, ld_last, ld_start,
    output data_fromRAM, ld_ready, ld_overflow, cpu_rst
  );

  modport master (
    output wrEn, addr_toRAM, data_toRAM, ld_valid, ld_byte, ld_last, ld_start,
    input  data_fromRAM, ld_ready, ld_overflow, cpu_rst
  );
endinterface

// File: rtl/vscpu_ram_loader.sv
// Word RAM for the VerySimpleCPU with a byte-serial boot loader in front.
// After reset the loader owns the RAM and holds the CPU in reset; bytes are
// packed little-endian into 32-bit words and committed from address 0 up.
// The image's last byte releases the CPU; ld_start in RUN starts a reload.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - vscpu_ram_loader_if.slave (CPU RAM port + loader handshake)
module vscpu_ram_loader #(
  parameter int SIZE  = 14,
  parameter int DEPTH = 16384
) (
  input  logic                 clk,
  input  logic                 rst,
  vscpu_ram_loader_if.slave    bus
);
  localparam int             IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SIZE:0]  DEPTH_L = (SIZE+1)'(DEPTH);

  typedef enum logic [1:0] {S_LOAD, S_COMMIT, S_RUN} state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_byte_cnt;
  logic [SIZE:0] r_ld_addr;   // one extra bit so it can rest at DEPTH
  logic [31:0]   r_shift;
  logic          r_last;
  logic          r_overflow;
  logic [31:0]   r_rdata;

  logic [31:0]   mem [DEPTH];

  logic          w_accept;
  logic          w_cpu_in;
  logic          w_we;
  logic [IW-1:0] w_waddr;
  logic [31:0]   w_wdata;

  assign w_accept = (r_state == S_LOAD) && bus.ld_valid;
  assign w_cpu_in = {1'b0, bus.addr_toRAM} < DEPTH_L;

  assign bus.cpu_rst      = (r_state != S_RUN);
  assign bus.ld_ready     = (r_state == S_LOAD);
  assign bus.ld_overflow  = r_overflow;
  assign bus.data_fromRAM = r_rdata;

  // Single write port shared by the loader (COMMIT) and the CPU (RUN).
  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_waddr = bus.addr_toRAM[IW-1:0];
    w_wdata = bus.data_toRAM;
    case (r_state)
      S_LOAD: begin
        if (w_accept && (r_byte_cnt == 2'd3 || bus.ld_last)) w_next = S_COMMIT;
      end
      S_COMMIT: begin
        w_next  = r_last ? S_RUN : S_LOAD;
        w_we    = (r_ld_addr < DEPTH_L);
        w_waddr = r_ld_addr[IW-1:0];
        w_wdata = r_shift;
      end
      S_RUN: begin
        if (bus.ld_start) w_next = S_LOAD;
        w_we = bus.wrEn && w_cpu_in;
      end
      default: w_next = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_LOAD;
      r_byte_cnt <= '0;
      r_ld_addr  <= '0;
      r_shift    <= '0;
      r_last     <= 1'b0;
      r_overflow <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_next;
      // Reads see the array before this edge's write: old data on collision.
      if (r_state == S_RUN && w_cpu_in) r_rdata <= mem[bus.addr_toRAM[IW-1:0]];
      else                              r_rdata <= '0;
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            r_shift[{r_byte_cnt, 3'b000} +: 8] <= bus.ld_byte;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_last     <= bus.ld_last;
          end
        end
        S_COMMIT: begin
          if (r_ld_addr >= DEPTH_L) r_overflow <= 1'b1;
          else                      r_ld_addr  <= r_ld_addr + 1'b1;
          r_byte_cnt <= '0;
          r_shift    <= '0;  // zero-fills the unreceived bytes of a short word
          r_last     <= 1'b0;
        end
        S_RUN: begin
          if (bus.ld_start) begin
            r_ld_addr  <= '0;
            r_byte_cnt <= '0;
            r_overflow <= 1'b0;
            r_last     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
